// File: rtl/bf_pkg.sv
// Shared definitions for the buffered UART transmitter: serialiser state
// encoding and the idle line level.
package bf_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bf_fifo.sv
// Synchronous FIFO with registered full/empty flags and a sticky overflow flag.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bf_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             r_full;
   logic             r_empty;
   logic             r_overflow;

   logic             w_push;
   logic             w_pop;
   logic [AW:0]      w_wr_ptr_nxt;
   logic [AW:0]      w_rd_ptr_nxt;

   // A pop in the same cycle never frees a slot for the write: gate on current full.
   assign w_push       = i_wr_en && !r_full;
   assign w_pop        = i_rd_en && !r_empty;
   assign w_wr_ptr_nxt = w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
   assign w_rd_ptr_nxt = w_pop  ? r_rd_ptr + 1'b1 : r_rd_ptr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_full   <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                     (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
         r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
         if (i_wr_en && r_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
      end
   end

   assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_full     = r_full;
   assign o_empty    = r_empty;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: frames start, LSB-first data, optional even
// parity (UART_TX_PARITY_EN) and stop bits onto a registered serial line.
module uart_tx_fifo
   import bf_pkg::*;
#(
   parameter int UART_TX_BAUD = 4,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] stdout,
   input  logic                 stdout_en,
   output logic                 uart_tx_pin,
   output logic                 full,
   output logic                 empty,
   output logic                 busy,
   output logic                 overflow,
   output uart_tx_state_t       o_dbg_state
);

   localparam int CNT_W = $clog2(STOP_BITS * UART_TX_BAUD + 1);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(UART_TX_BAUD - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * UART_TX_BAUD - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

   uart_tx_state_t       r_state;
   logic [CNT_W-1:0]     r_baud_cnt;
   logic [BIT_W-1:0]     r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_pin;
   logic                 r_busy;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
`endif

   logic                 w_pop;
   logic                 w_empty;
   logic                 w_pin_nxt;
   logic [DATA_BITS-1:0] w_rd_data;

   assign w_pop = (r_state == IDLE) && !w_empty;

   bf_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_wr_en    (stdout_en),
      .i_wr_data  (stdout),
      .i_rd_en    (w_pop),
      .o_rd_data  (w_rd_data),
      .o_full     (full),
      .o_empty    (w_empty),
      .o_overflow (overflow)
   );

   // Line level for the current state; registered below so the pin never glitches.
   always_comb begin
      w_pin_nxt = UART_IDLE_LEVEL;
      case (r_state)
         IDLE:    w_pin_nxt = UART_IDLE_LEVEL;
         START:   w_pin_nxt = 1'b0;
         DATA:    w_pin_nxt = r_shift[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_pin_nxt = r_parity;
`endif
         STOP:    w_pin_nxt = 1'b1;
         default: w_pin_nxt = UART_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_pin      <= UART_IDLE_LEVEL;
         r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_pin <= w_pin_nxt;
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_shift    <= w_rd_data;
`ifdef UART_TX_PARITY_EN
                  r_parity   <= ^w_rd_data;
`endif
                  r_baud_cnt <= '0;
                  r_bit_idx  <= '0;
                  r_state    <= START;
                  r_busy     <= 1'b1;
               end
            end
            START: begin
               if (r_baud_cnt == BAUD_LAST) begin
                  r_baud_cnt <= '0;
                  r_state    <= DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (r_baud_cnt == BAUD_LAST) begin
                  r_baud_cnt <= '0;
                  r_shift    <= r_shift >> 1;
                  if (r_bit_idx == LAST_BIT) begin
                     r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     r_state   <= PARITY;
`else
                     r_state   <= STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (r_baud_cnt == BAUD_LAST) begin
                  r_baud_cnt <= '0;
                  r_state    <= STOP;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (r_baud_cnt == STOP_LAST) begin
                  r_baud_cnt <= '0;
                  r_state    <= IDLE;
                  r_busy     <= 1'b0;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign uart_tx_pin = r_pin;
   assign busy        = r_busy;
   assign empty       = w_empty;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized checks of uart_tx_fifo against a waveform/queue model
// derived from the frame format (start, LSB-first data, optional parity, stop).
module tb_uart_tx_fifo;
   import bf_pkg::*;

   localparam int B  = 4;
   localparam int D  = 8;
   localparam int S  = 1;
   localparam int FD = 16;
`ifdef UART_TX_PARITY_EN
   localparam int P  = 1;
`else
   localparam int P  = 0;
`endif
   localparam int FRAME_LEN = (1 + D + P + S) * B;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [D-1:0] stdout = '0;
   logic         stdout_en = 1'b0;
   logic         uart_tx_pin;
   logic         full;
   logic         empty;
   logic         busy;
   logic         overflow;
   uart_tx_state_t dbg_state;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic         line_q[$];
   logic         exp_wave[$];
   logic [D-1:0] exp_q[$];
   logic [D-1:0] got_q[$];
   logic [D-1:0] fifo_m[$];

   uart_tx_fifo #(
      .UART_TX_BAUD (B),
      .DATA_BITS    (D),
      .STOP_BITS    (S),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stdout      (stdout),
      .stdout_en   (stdout_en),
      .uart_tx_pin (uart_tx_pin),
      .full        (full),
      .empty       (empty),
      .busy        (busy),
      .overflow    (overflow),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: wait for the falling edge and record the line level.
   task automatic step();
      @(negedge clk);
      line_q.push_back(uart_tx_pin);
   endtask

   task automatic wr(input logic [D-1:0] w);
      stdout    = w;
      stdout_en = 1'b1;
      step();
      stdout_en = 1'b0;
   endtask

   task automatic add_frame(input logic [D-1:0] w);
      repeat (B) exp_wave.push_back(1'b0);
      for (int k = 0; k < D; k++) repeat (B) exp_wave.push_back(w[k]);
      if (P == 1) repeat (B) exp_wave.push_back(^w);
      repeat (S * B) exp_wave.push_back(1'b1);
   endtask

   task automatic wave_mismatches(output int bad);
      bad = 0;
      for (int i = 0; i < exp_wave.size(); i++) begin
         if (i >= line_q.size() || line_q[i] !== exp_wave[i]) bad++;
      end
   endtask

   // Recover words from the recorded line by sampling each bit mid-period.
   task automatic decode_line(output int n_bad);
      int i;
      logic [D-1:0] w;
      n_bad = 0;
      got_q.delete();
      i = 0;
      while (i + FRAME_LEN <= line_q.size()) begin
         if (line_q[i] === 1'b0) begin
            if (line_q[i + B/2] !== 1'b0) n_bad++;
            for (int k = 0; k < D; k++) w[k] = line_q[i + B*(1+k) + B/2];
            if (P == 1 && line_q[i + B*(1+D) + B/2] !== ^w) n_bad++;
            for (int s = 0; s < S; s++)
               if (line_q[i + B*(1+D+P+s) + B/2] !== 1'b1) n_bad++;
            got_q.push_back(w);
            i += FRAME_LEN;
         end else begin
            i++;
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy !== 1'b0 || empty !== 1'b1) && n < 3000) begin
         step();
         n++;
      end
      chk({tag, "_idle_timeout"}, 32'(n < 3000), 32'd1);
   endtask

   task automatic compare_frames(input string tag);
      int bad;
      decode_line(bad);
      chk({tag, "_framing"}, 32'(bad), 32'd0);
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      int bad;
      logic [D-1:0] w;
      logic exp_full;
      logic exp_ovf;

      // Reset and 100 idle cycles
      repeat (3) @(negedge clk);
      chk("rst_pin", 32'(uart_tx_pin), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         step();
         if (uart_tx_pin !== 1'b1 || empty !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("idle_100", 32'(bad), 32'd0);

      // Single word 0x41: exact waveform, start bit two cycles after the write
      line_q.delete();
      exp_wave.delete();
      wr(8'h41);
      chk("single_empty_after_push", 32'(empty), 32'd0);
      step();
      chk("single_busy_after_pop", 32'(busy), 32'd1);
      chk("single_state_start", 32'(dbg_state), 32'(START));
      repeat (60) step();
      exp_wave.push_back(1'b1);
      exp_wave.push_back(1'b1);
      add_frame(8'h41);
      repeat (20) exp_wave.push_back(1'b1);
      chk("single_start_latency", 32'(line_q[2]), 32'd0);
      wave_mismatches(bad);
      chk("single_wave", 32'(bad), 32'd0);
      wait_idle("single");

      // "Hi" on consecutive cycles: exactly one idle-high cycle between frames
      line_q.delete();
      exp_wave.delete();
      stdout = 8'h48;
      stdout_en = 1'b1;
      step();
      stdout = 8'h69;
      step();
      stdout_en = 1'b0;
      repeat (110) step();
      exp_wave.push_back(1'b1);
      exp_wave.push_back(1'b1);
      add_frame(8'h48);
      exp_wave.push_back(1'b1);
      add_frame(8'h69);
      repeat (20) exp_wave.push_back(1'b1);
      chk("hi_gap_high", 32'(line_q[2 + FRAME_LEN]), 32'd1);
      chk("hi_second_start", 32'(line_q[3 + FRAME_LEN]), 32'd0);
      wave_mismatches(bad);
      chk("hi_wave", 32'(bad), 32'd0);
      exp_q.delete();
      exp_q.push_back(8'h48);
      exp_q.push_back(8'h69);
      compare_frames("hi");
      wait_idle("hi");

      // Random words with random gaps
      line_q.delete();
      exp_q.delete();
      repeat (5) step();
      for (int n = 0; n < 8; n++) begin
         repeat ($urandom_range(0, 50)) step();
         w = D'($urandom);
         exp_q.push_back(w);
         wr(w);
      end
      wait_idle("rand");
      repeat (5) step();
      compare_frames("rand");

      // Burst of 17 while a frame is in flight: 16 buffered, last one dropped
      line_q.delete();
      exp_q.delete();
      fifo_m.delete();
      repeat (3) step();
      w = D'($urandom);
      exp_q.push_back(w);
      wr(w);
      repeat (3) step();
      exp_full = 1'b0;
      exp_ovf  = 1'b0;
      for (int i = 0; i < 17; i++) begin
         step();
         if (i > 0) begin
            chk($sformatf("burst_full_w%0d", i), 32'(full), 32'(exp_full));
            chk($sformatf("burst_ovf_w%0d", i), 32'(overflow), 32'(exp_ovf));
         end
         w = D'($urandom);
         if (fifo_m.size() < FD) begin
            fifo_m.push_back(w);
            exp_q.push_back(w);
         end else begin
            exp_ovf = 1'b1;
         end
         exp_full = (fifo_m.size() == FD);
         stdout = w;
         stdout_en = 1'b1;
      end
      step();
      stdout_en = 1'b0;
      chk("burst_full_w17", 32'(full), 32'(exp_full));
      chk("burst_ovf_w17", 32'(overflow), 32'(exp_ovf));
      wait_idle("burst");
      repeat (5) step();
      compare_frames("burst");
      chk("burst_ovf_sticky", 32'(overflow), 32'd1);

      // Asynchronous reset in the middle of the data bits with words queued
      repeat (4) begin
         w = D'($urandom);
         stdout = w;
         stdout_en = 1'b1;
         step();
      end
      stdout_en = 1'b0;
      repeat (12) step();
      chk("midrst_busy_before", 32'(busy), 32'd1);
      chk("midrst_state_before", 32'(dbg_state), 32'(DATA));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_pin", 32'(uart_tx_pin), 32'd1);
      chk("midrst_empty", 32'(empty), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_overflow", 32'(overflow), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      line_q.delete();
      bad = 0;
      repeat (100) begin
         step();
         if (uart_tx_pin !== 1'b1 || empty !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("midrst_quiet_after", 32'(bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
